// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative HI/LO multiply/divide unit (shift-add multiply, restoring divide).
// Define MDU_SIGNED_EN to enable signed MULT/DIV; otherwise ops 001/011 act as 000/010.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] md_q, md_d, a_q, a_d, hi_q, hi_d, lo_q, lo_d;
  logic div_q, div_d, done_q, done_d;
  logic [WIDTH-1:0] ma, mb, quo, rem, sub;
  logic [WIDTH:0] mul_sum, rem_sh;
  logic ge;
  logic [2*WIDTH-1:0] mul_step, div_step, prod;
`ifdef MDU_SIGNED_EN
  logic sa, sb, negp_q, negp_d, negr_q, negr_d;
  assign sa = op[0] & a[WIDTH-1];
  assign sb = op[0] & b[WIDTH-1];
  assign ma = sa ? -a : a;
  assign mb = sb ? -b : b;
  assign prod = negp_q ? -acc_q : acc_q;
  assign quo = negp_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem = negr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  assign negp_d = (state_q == IDLE && start && !op[2]) ? sa ^ sb : negp_q;
  assign negr_d = (state_q == IDLE && start && !op[2]) ? sa : negr_q;
  always_ff @(posedge clock) begin
    if (!resetn) begin
      negp_q <= 1'b0;
      negr_q <= 1'b0;
    end else begin
      negp_q <= negp_d;
      negr_q <= negr_d;
    end
  end
`else
  logic unused_op;
  assign unused_op = op[0];
  assign ma = a;
  assign mb = b;
  assign prod = acc_q;
  assign quo = acc_q[WIDTH-1:0];
  assign rem = acc_q[2*WIDTH-1:WIDTH];
`endif
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, acc_q[0] ? md_q : {WIDTH{1'b0}}};
  assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};
  // Partial remainder shifted left with the next dividend bit; it never exceeds 2*divisor.
  assign rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
  assign ge = rem_sh >= {1'b0, md_q};
  assign sub = rem_sh[WIDTH-1:0] - md_q;
  assign div_step = ge ? {sub, acc_q[WIDTH-2:0], 1'b1} : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    md_d = md_q;
    a_d = a_q;
    div_d = div_q;
    hi_d = hi_q;
    lo_d = lo_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        hi_d = wr_hi ? wdata : hi_q;
        lo_d = wr_lo ? wdata : lo_q;
        if (start && !op[2]) begin
          state_d = RUN;
          cnt_d = '0;
          acc_d = {{WIDTH{1'b0}}, ma};
          md_d = mb;
          a_d = a;
          div_d = op[1];
        end
      end
      RUN: begin
        acc_d = div_q ? div_step : mul_step;
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == '1) ? FIX : RUN;
      end
      FIX: begin
        {hi_d, lo_d} = div_q ? ((md_q == '0) ? {a_q, {WIDTH{1'b1}}} : {rem, quo}) : prod;
        done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      md_q <= '0;
      a_q <= '0;
      div_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      md_q <= md_d;
      a_q <= a_d;
      div_q <= div_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      done_q <= done_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: table-driven and scoreboard checks of mul_div_unit (honours MDU_SIGNED_EN).
module tb_mul_div_unit;
  logic clock = 1'b0;
  logic resetn, start, wr_hi, wr_lo, busy, done;
  logic [2:0] op;
  logic [31:0] a, b, wdata, hi, lo;
  int compared = 0;
  int mismatched = 0;
  logic [63:0] sb_q[$];
  typedef struct packed {
    logic [2:0] op;
    logic [31:0] a, b, hi, lo;
  } vec_t;
  vec_t tbl[12];
`ifdef MDU_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif
  always #5 clock = ~clock;
  mul_div_unit #(.WIDTH(32)) dut (
    .clock(clock), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic s;
    logic signed [63:0] px, py;
    logic signed [31:0] sx, sy;
    s = SGN && o[0];
    sx = x;
    sy = y;
    px = s ? {{32{x[31]}}, x} : {32'b0, x};
    py = s ? {{32{y[31]}}, y} : {32'b0, y};
    if (!o[1]) return px * py;
    if (y == 32'd0) return {x, 32'hFFFFFFFF};
    if (!s) return {x % y, x / y};
    if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
    return {sx % sy, sx / sy};
  endfunction
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic start_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic [63:0] e);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    sb_q.push_back(e);
    tick;
    start = 1'b0;
    op = 3'($urandom_range(0, 3));
    a = $urandom;
    b = $urandom;
  endtask
  task automatic wait_done(input string n, input int exp_lat);
    int lat = 0;
    int bc = 0;
    logic [63:0] e;
    while (!done && lat < 100) begin
      if (busy) bc++;
      tick;
      lat++;
    end
    check({n, "_lat"}, 64'(lat), 64'(exp_lat));
    check({n, "_busy"}, 64'(bc), 64'(exp_lat));
    if (sb_q.size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL %s_sb: got done with no expected entry", n);
    end else begin
      e = sb_q.pop_front();
      check({n, "_res"}, {hi, lo}, e);
    end
    tick;
    check({n, "_pulse"}, 64'(done), 64'd0);
  endtask
  initial begin
    int nd;
    logic [2:0] o;
    logic [31:0] x, y;
    resetn = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0;
    wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
    tick;
    tick;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    resetn = 1'b1;
    tbl[0]  = '{3'b000, 32'hFFFFFFFF, 32'd2, 32'd1, 32'hFFFFFFFE};
    tbl[1]  = '{3'b001, 32'hFFFFFFFD, 32'd7, SGN ? 32'hFFFFFFFF : 32'd6, 32'hFFFFFFEB};
    tbl[2]  = '{3'b011, 32'hFFFFFFF9, 32'd2, SGN ? 32'hFFFFFFFF : 32'd1, SGN ? 32'hFFFFFFFD : 32'h7FFFFFFC};
    tbl[3]  = '{3'b010, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF};
    tbl[4]  = '{3'b011, 32'h80000000, 32'hFFFFFFFF, SGN ? 32'd0 : 32'h80000000, SGN ? 32'h80000000 : 32'd0};
    tbl[5]  = '{3'b000, 32'd6, 32'd7, 32'd0, 32'd42};
    tbl[6]  = '{3'b011, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF};
    tbl[7]  = '{3'b010, 32'hFFFFFFFF, 32'd16, 32'hF, 32'h0FFFFFFF};
    tbl[8]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0};
    tbl[9]  = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1};
    tbl[10] = '{3'b011, 32'd7, 32'hFFFFFFFE, SGN ? 32'd1 : 32'd7, SGN ? 32'hFFFFFFFD : 32'd0};
    tbl[11] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, SGN ? 32'd0 : 32'hFFFFFFFE, 32'd1};
    for (int i = 0; i < 12; i++) begin
      start_op(tbl[i].op, tbl[i].a, tbl[i].b, {tbl[i].hi, tbl[i].lo});
      wait_done($sformatf("vec%0d", i), 33);
    end
    for (int i = 0; i < 8; i++) begin
      o = 3'($urandom_range(0, 3));
      x = $urandom;
      y = (i == 3) ? 32'd0 : ((i % 2 == 0) ? 32'($urandom_range(1, 255)) : $urandom);
      start_op(o, x, y, model(o, x, y));
      wait_done($sformatf("rnd%0d", i), 33);
    end
    start_op(3'b010, 32'd1000, 32'd7, {32'd6, 32'd142});
    repeat (4) tick;
    start = 1'b1; op = 3'b000; a = 32'd5; b = 32'd5;
    tick;
    start = 1'b0;
    repeat (4) tick;
    wr_lo = 1'b1; wdata = 32'hDEADBEEF;
    tick;
    wr_lo = 1'b0;
    wait_done("ignore", 23);
    nd = 0;
    repeat (40) begin
      tick;
      if (done) nd++;
    end
    check("no_extra_done", 64'(nd), 64'd0);
    check("lo_kept", 64'(lo), 64'd142);
    wr_hi = 1'b1; wdata = 32'hCAFE0001;
    start_op(3'b000, 32'd3, 32'd5, {32'd0, 32'd15});
    wr_hi = 1'b0;
    check("coincide_hi", 64'(hi), 64'hCAFE0001);
    wait_done("coincide", 33);
    wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h12345678;
    tick;
    wr_hi = 1'b0; wr_lo = 1'b0;
    check("mt_hilo", {hi, lo}, {32'h12345678, 32'h12345678});
    check("mt_done", 64'(done), 64'd0);
    start = 1'b1; op = 3'b101; a = 32'd9; b = 32'd9;
    tick;
    start = 1'b0;
    check("rsv_busy", 64'(busy), 64'd0);
    tick;
    check("rsv_done", 64'(done), 64'd0);
    check("rsv_hilo", {hi, lo}, {32'h12345678, 32'h12345678});
    start_op(3'b010, 32'hFFFF0000, 32'd3, model(3'b010, 32'hFFFF0000, 32'd3));
    repeat (11) tick;
    resetn = 1'b0;
    tick;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    void'(sb_q.pop_front());
    resetn = 1'b1;
    start_op(3'b000, 32'd6, 32'd7, {32'd0, 32'd42});
    wait_done("post_reset", 33);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
